// File: rtl/hazard_stall_ctrl.sv
// Purpose: pipeline hazard control; stall/flush/bubble generation for load-use, taken branch and data-memory waits.
// Latency: control outputs are combinational from inputs and FSM state; counters and the error flag update on the next edge.
// Backpressure: an outstanding memory access without ack freezes the entire pipeline; timeout locks the freeze until reset.
module hazard_stall_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_uses_rs2_i,
  input  logic             ex_memread_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             branch_taken_i,
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  output logic             pc_write_o,
  output logic             if_id_stall_o,
  output logic             if_id_flush_o,
  output logic             id_ex_stall_o,
  output logic             id_ex_flush_o,
  output logic             ex_mem_stall_o,
  output logic             mem_wb_bubble_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic             timeout_o
);

  localparam int WC_W = $clog2(TIMEOUT);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {ST_RUN, ST_WAIT, ST_ERR} state_e;

  state_e           state_q, state_d;
  logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             timeout_q, timeout_d;

  logic freeze;
  logic load_use;

  // Hazard detection: memory freeze dominates the register-dependency check.
  always_comb begin
    freeze = ((state_q == ST_RUN)  && mem_req_i && !mem_ack_i) ||
             ((state_q == ST_WAIT) && !mem_ack_i) ||
             (state_q == ST_ERR);
    load_use = ex_memread_i && (ex_rd_i != 5'd0) &&
               ((ex_rd_i == id_rs1_i) || (id_uses_rs2_i && (ex_rd_i == id_rs2_i)));
  end

  // Pipeline controls in priority order: reset, freeze, load-use, branch, normal.
  always_comb begin
    pc_write_o      = 1'b1;
    if_id_stall_o   = 1'b0;
    if_id_flush_o   = 1'b0;
    id_ex_stall_o   = 1'b0;
    id_ex_flush_o   = 1'b0;
    ex_mem_stall_o  = 1'b0;
    mem_wb_bubble_o = 1'b0;
    if (rst_i) begin
      pc_write_o    = 1'b0;
      if_id_flush_o = 1'b1;
      id_ex_flush_o = 1'b1;
    end else if (freeze) begin
      pc_write_o      = 1'b0;
      if_id_stall_o   = 1'b1;
      id_ex_stall_o   = 1'b1;
      ex_mem_stall_o  = 1'b1;
      mem_wb_bubble_o = 1'b1;
    end else if (load_use) begin
      // A taken branch here is dropped; ID re-resolves it next cycle with forwarded data.
      pc_write_o    = 1'b0;
      if_id_stall_o = 1'b1;
      id_ex_flush_o = 1'b1;
    end else if (branch_taken_i) begin
      if_id_flush_o = 1'b1;
    end
  end

  // Memory-wait FSM next state, wait counter, sticky timeout and saturating stall counter.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    timeout_d   = timeout_q;
    stall_cnt_d = stall_cnt_q;
    unique case (state_q)
      ST_RUN: begin
        if (mem_req_i && !mem_ack_i) begin
          state_d    = ST_WAIT;
          wait_cnt_d = '0;
        end
      end
      ST_WAIT: begin
        // An ack always wins, even if a new request is raised the same cycle.
        if (mem_ack_i) begin
          state_d = ST_RUN;
        end else if (wait_cnt_q == WC_LAST) begin
          state_d   = ST_ERR;
          timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WC_W'(1);
        end
      end
      ST_ERR: state_d = ST_ERR;
      default: state_d = ST_RUN;
    endcase
    if (!pc_write_o && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // State registers; reset aborts any pending access.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed test-plan steps followed by random traffic against a behavioural model.
module tb_hazard_stall_ctrl;
  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic [4:0] id_rs1_i = '0, id_rs2_i = '0, ex_rd_i = '0;
  logic id_uses_rs2_i = 1'b0, ex_memread_i = 1'b0, branch_taken_i = 1'b0;
  logic mem_req_i = 1'b0, mem_ack_i = 1'b0;
  logic pc_write_o, if_id_stall_o, if_id_flush_o, id_ex_stall_o, id_ex_flush_o;
  logic ex_mem_stall_o, mem_wb_bubble_o, timeout_o;
  logic [CNT_W-1:0] stall_cnt_o;

  int checks = 0;
  int errors = 0;

  // Reference model: an outstanding access, how long it has waited, and a dead-bus flag.
  bit m_pending = 0;
  int m_waited  = 0;
  bit m_dead    = 0;
  int m_stalls  = 0;

  hazard_stall_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_uses_rs2_i(id_uses_rs2_i),
    .ex_memread_i(ex_memread_i), .ex_rd_i(ex_rd_i), .branch_taken_i(branch_taken_i),
    .mem_req_i(mem_req_i), .mem_ack_i(mem_ack_i),
    .pc_write_o(pc_write_o), .if_id_stall_o(if_id_stall_o), .if_id_flush_o(if_id_flush_o),
    .id_ex_stall_o(id_ex_stall_o), .id_ex_flush_o(id_ex_flush_o),
    .ex_mem_stall_o(ex_mem_stall_o), .mem_wb_bubble_o(mem_wb_bubble_o),
    .stall_cnt_o(stall_cnt_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive after the falling edge, check outputs, then advance the model past the rising edge.
  // Control vector order: {pc_write, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_bubble}.
  task automatic cycle(input bit rst, input int rs1, input int rs2, input bit use2,
                       input bit ld, input int rd, input bit br, input bit req, input bit ack);
    bit frz, lu;
    logic [6:0] exp_ctrl;
    @(negedge clk);
    rst_i = rst; id_rs1_i = 5'(rs1); id_rs2_i = 5'(rs2); id_uses_rs2_i = use2;
    ex_memread_i = ld; ex_rd_i = 5'(rd); branch_taken_i = br; mem_req_i = req; mem_ack_i = ack;
    #1;
    frz = m_dead || (m_pending && !ack) || (!m_pending && req && !ack);
    lu  = ld && rd != 0 && (rd == rs1 || (use2 && rd == rs2));
    if (rst)      exp_ctrl = 7'b0010100;
    else if (frz) exp_ctrl = 7'b0101011;
    else if (lu)  exp_ctrl = 7'b0100100;
    else if (br)  exp_ctrl = 7'b1010000;
    else          exp_ctrl = 7'b1000000;
    check("ctrl", {pc_write_o, if_id_stall_o, if_id_flush_o, id_ex_stall_o,
                   id_ex_flush_o, ex_mem_stall_o, mem_wb_bubble_o}, 32'(exp_ctrl));
    check("stall_cnt", 32'(stall_cnt_o), 32'(m_stalls));
    check("timeout", 32'(timeout_o), 32'(m_dead));
    if (rst) begin
      m_pending = 0; m_waited = 0; m_dead = 0; m_stalls = 0;
    end else begin
      if (!exp_ctrl[6] && m_stalls < CNT_MAX) m_stalls++;
      if (m_dead) begin
        // stays dead until reset
      end else if (m_pending) begin
        if (ack) m_pending = 0;
        else if (m_waited + 1 >= TIMEOUT) begin m_dead = 1; m_pending = 0; end
        else m_waited++;
      end else if (req && !ack) begin
        m_pending = 1; m_waited = 0;
      end
    end
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic reset1();
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // Reset held two cycles, then normal operation.
    reset1(); reset1();
    idle();
    check("post_reset_pc_write", 32'(pc_write_o), 32'd1);

    // Load-use on rs1, then the load has advanced.
    cycle(0, 5, 0, 0, 1, 5, 0, 0, 0);
    idle();
    // Load into x0 never stalls.
    cycle(0, 0, 0, 0, 1, 0, 0, 0, 0);
    // rs2 match ignored when rs2 not read, honoured when it is.
    cycle(0, 1, 7, 0, 1, 7, 0, 0, 0);
    cycle(0, 1, 7, 1, 1, 7, 0, 0, 0);
    // Branch alone flushes; branch under load-use only stalls.
    cycle(0, 2, 3, 1, 0, 0, 1, 0, 0);
    cycle(0, 4, 3, 1, 1, 4, 1, 0, 0);
    idle();
    check("stall_cnt_directed", 32'(stall_cnt_o), 32'd3);

    // Memory wait: ack arrives three cycles after the request.
    reset1();
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle();
    check("mem_wait_stalls", 32'(stall_cnt_o), 32'd3);
    // Same-cycle ack: no freeze, pipeline keeps moving.
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 1);
    check("same_cycle_ack_pc_write", 32'(pc_write_o), 32'd1);
    idle();

    // Timeout: request never acknowledged.
    reset1();
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0, 0, 0, 0, 1, 0);
    check("timeout_set", 32'(timeout_o), 32'd1);
    idle();
    check("err_freeze_held", 32'(ex_mem_stall_o), 32'd1);
    reset1();
    idle();
    check("timeout_cleared", 32'(timeout_o), 32'd0);

    // Saturation: ten load-use cycles into a 3-bit counter.
    reset1();
    for (int i = 0; i < 10; i++) cycle(0, 9, 0, 0, 1, 9, 0, 0, 0);
    idle();
    check("stall_cnt_saturated", 32'(stall_cnt_o), 32'd7);

    // Randomized traffic with occasional resets; small register range to provoke matches.
    reset1();
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 39) == 0,
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom),
            1'($urandom), int'($urandom_range(0, 3)), 1'($urandom),
            $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
